// File: rtl/tff_count_sequencer_if.sv
// rtl/tff_count_sequencer_if.sv - control/status bundle for the T-FF count sequencer
interface tff_count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, dir, mode, limit, load, load_val,
        input  q, qb, t_vec, busy, tc, done
    );

    modport slave (
        input  start, stop, dir, mode, limit, load, load_val,
        output q, qb, t_vec, busy, tc, done
    );
endinterface

// File: rtl/tff_count_sequencer.sv
// rtl/tff_count_sequencer.sv - T-FF bank counter sequencer; optional prescaler via TFF_SEQ_PRESCALE_EN
module tff_count_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tff_count_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             done_q, done_d;
    logic [PRE_W-1:0] pre_q, pre_d;

    logic [WIDTH-1:0] toggles;
    logic [WIDTH-1:0] t_vec_c;
    logic [WIDTH-1:0] terminal;
    logic             tc_c;
    logic             tick;

    // Candidate toggle pattern: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        logic run_and;
        toggles = '0;
        run_and = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggles[i] = run_and;
            run_and    = run_and & (dir_q ? ~q_q[i] : q_q[i]);
        end
    end

    // Advance strobe: every RUN cycle, or only when the prescale counter wraps
    always_comb begin
`ifdef TFF_SEQ_PRESCALE_EN
        tick = (pre_q == PRE_W'(PRESCALE - 1));
`else
        tick = 1'b1;
`endif
    end

    // Next-state, counter update and combinational outputs
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        limit_d  = limit_q;
        pre_d    = pre_q;
        t_vec_c  = '0;
        terminal = dir_q ? '0 : limit_q;
        tc_c     = (state_q == ST_RUN) && (q_q == terminal);

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    q_d = bus.load_val;
                end
                if (bus.start) begin
                    state_d = ST_RUN;
                    dir_d   = bus.dir;
                    mode_d  = bus.mode;
                    limit_d = bus.limit;
                    pre_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    // stop wins over start and suppresses this cycle's advance
                    state_d = ST_HOLD;
                end else begin
`ifdef TFF_SEQ_PRESCALE_EN
                    pre_d = tick ? '0 : pre_q + 1'b1;
`endif
                    if (tick) begin
                        if (tc_c) begin
                            if (mode_q) begin
                                state_d = ST_DONE;
                            end else begin
                                // wrap reloads directly rather than through toggles
                                q_d = dir_q ? limit_q : '0;
                            end
                        end else begin
                            t_vec_c = toggles;
                            q_d     = q_q ^ toggles;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (bus.load) begin
                    q_d = bus.load_val;
                end
                if (bus.start && !bus.stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
    end

    // State, counter and latched configuration registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            limit_q <= '0;
            done_q  <= 1'b0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.qb    = ~q_q;
    assign bus.t_vec = t_vec_c;
    assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign bus.tc    = tc_c;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb/tb_tff_count_sequencer.sv - directed self-checking bench for tff_count_sequencer
module tb_tff_count_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    tff_count_sequencer_if #(.WIDTH(4)) bus ();

    tff_count_sequencer #(.WIDTH(4), .PRESCALE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.dir      = 1'b0;
        bus.mode     = 1'b0;
        bus.limit    = 4'd0;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        step();
        step();
        chk("rst_q", bus.q, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_tc", bus.tc, 0);
        chk("rst_qb", bus.qb, 4'hF);

`ifndef TFF_SEQ_PRESCALE_EN
        // up-wrap, limit 5
        rst = 1'b1; bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 1'b0; bus.limit = 4'd5;
        step();
        bus.start = 1'b0;
        chk("up_first_q", bus.q, 0);
        chk("up_first_busy", bus.busy, 1);
        chk("up_first_tvec", bus.t_vec, 4'b0001);
        step(); chk("up_q1", bus.q, 1);
        step(); chk("up_q2", bus.q, 2);
        step(); chk("up_q3", bus.q, 3);
        chk("up_tvec_q3", bus.t_vec, 4'b0111);
        step(); chk("up_q4", bus.q, 4);
        chk("up_tc_q4", bus.tc, 0);
        step(); chk("up_q5", bus.q, 5);
        chk("up_tc_q5", bus.tc, 1);
        chk("up_tvec_reload", bus.t_vec, 0);
        step(); chk("up_wrap_q0", bus.q, 0);
        step(); chk("up_wrap_q1", bus.q, 1);

        rst = 1'b0; step(); rst = 1'b1;

        // down one-shot from a loaded 3
        bus.load = 1'b1; bus.load_val = 4'd3;
        step();
        chk("idle_load_q", bus.q, 3);
        chk("idle_load_busy", bus.busy, 0);
        bus.load = 1'b0; bus.start = 1'b1; bus.dir = 1'b1; bus.mode = 1'b1;
        step();
        bus.start = 1'b0; bus.dir = 1'b0; bus.mode = 1'b0;
        chk("dn_q3", bus.q, 3);
        chk("dn_tvec_q3", bus.t_vec, 4'b0001);
        step(); chk("dn_q2", bus.q, 2);
        step(); chk("dn_q1", bus.q, 1);
        step(); chk("dn_q0", bus.q, 0);
        chk("dn_tc_q0", bus.tc, 1);
        bus.start = 1'b1;
        step();
        chk("dn_done", bus.done, 1);
        chk("dn_done_busy", bus.busy, 0);
        chk("dn_done_q", bus.q, 0);
        chk("dn_done_tc", bus.tc, 0);
        step();
        bus.start = 1'b0;
        chk("dn_after_done", bus.done, 0);
        chk("dn_after_busy", bus.busy, 0);
        chk("dn_after_q", bus.q, 0);

        // pause and resume, limit 15
        bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 1'b0; bus.limit = 4'd15;
        step();
        bus.start = 1'b0;
        step(); step();
        chk("pr_q2", bus.q, 2);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("pr_hold_q", bus.q, 2);
        chk("pr_hold_tvec", bus.t_vec, 0);
        chk("pr_hold_busy", bus.busy, 1);
        bus.load = 1'b1; bus.load_val = 4'd9;
        step();
        bus.load = 1'b0;
        chk("pr_hold_load", bus.q, 9);
        bus.start = 1'b1; bus.dir = 1'b1;
        step();
        bus.start = 1'b0; bus.dir = 1'b0;
        chk("pr_resume_q", bus.q, 9);
        for (int v = 10; v <= 15; v++) begin
            step();
            chk($sformatf("pr_up_%0d", v), bus.q, v);
        end
        step(); chk("pr_wrap_q0", bus.q, 0);

        // load ignored in RUN; start+stop goes to HOLD
        bus.load = 1'b1; bus.load_val = 4'd7;
        step();
        bus.load = 1'b0;
        chk("run_load_ignored", bus.q, 1);
        bus.start = 1'b1; bus.stop = 1'b1;
        step();
        chk("startstop_hold_q", bus.q, 1);
        chk("startstop_tvec", bus.t_vec, 0);
        bus.stop = 1'b0;
        step();
        bus.start = 1'b0;
        chk("startstop_resume_q", bus.q, 1);
        for (int k = 0; k < 6; k++) step();
        chk("run_q7", bus.q, 7);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_q", bus.q, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        step();
        chk("midrst_done2", bus.done, 0);
        chk("midrst_idle_q", bus.q, 0);

        // limit 0 up-wrap stays at 0 with tc every cycle
        bus.start = 1'b1; bus.limit = 4'd0;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lim0_q_%0d", k), bus.q, 0);
            chk($sformatf("lim0_tc_%0d", k), bus.tc, 1);
            step();
        end

        rst = 1'b0; step(); rst = 1'b1;

        // down-wrap from 0 with limit 12
        bus.start = 1'b1; bus.dir = 1'b1; bus.limit = 4'd12;
        step();
        bus.start = 1'b0;
        chk("dw_tc_q0", bus.tc, 1);
        step(); chk("dw_q12", bus.q, 12);
        step(); chk("dw_q11", bus.q, 11);
        chk("dw_tvec_q11", bus.t_vec, 4'b0001);
`else
        // prescaled up count: one advance every 4 clocks, phase kept across HOLD
        rst = 1'b1; bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 1'b0; bus.limit = 4'd15;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        chk("ps_q0_hold", bus.q, 0);
        chk("ps_tvec_tick", bus.t_vec, 4'b0001);
        step();
        chk("ps_q1", bus.q, 1);
        chk("ps_tvec_idle", bus.t_vec, 0);
        step(); step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();
        chk("ps_hold_q", bus.q, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("ps_phase_q", bus.q, 1);
        step();
        chk("ps_q2", bus.q, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
